// File: rtl/dc_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel
// between INPUTS requesters, with optional packet locking on c_last.
module dc_rr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int INPUTS  = 4,
    parameter int LOCKING = 1,
    localparam int GW     = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [INPUTS-1:0]         c_valid,
    input  logic [INPUTS*WIDTH-1:0]   c_data,
    input  logic [INPUTS-1:0]         c_last,
    output logic [INPUTS-1:0]         c_ready,
    output logic                      p_valid,
    output logic [WIDTH-1:0]          p_data,
    output logic [GW-1:0]             p_grant,
    output logic                      p_last,
    input  logic                      p_ready
);

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [GW-1:0]     r_grant;
    logic              r_last;
    logic              r_lock;
    logic [GW-1:0]     r_lock_idx;
    logic [GW-1:0]     r_last_grant;

    logic              w_load;
    logic [GW-1:0]     w_scan_sel;
    logic [GW-1:0]     w_idx;
    logic [GW-1:0]     w_sel;
    logic [INPUTS-1:0] w_ready;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_data;
    logic              w_last;

    assign w_load = !r_valid || p_ready;

    // Descending scan: the nearest valid requester after last_grant wins.
    always_comb begin
        w_scan_sel = r_last_grant;
        w_idx      = '0;
        for (int k = INPUTS; k >= 1; k--) begin
            w_idx = GW'((int'(r_last_grant) + k) % INPUTS);
            if (c_valid[w_idx]) begin
                w_scan_sel = w_idx;
            end
        end
    end

    assign w_sel = r_lock ? r_lock_idx : w_scan_sel;

    // A locked input keeps ready even while idle, so no one else can win.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_ready[i] = reset && w_load && (GW'(i) == w_sel)
                         && (r_lock || c_valid[i]);
        end
    end

    assign c_ready = w_ready;
    assign w_xfer  = |(w_ready & c_valid);
    assign w_data  = c_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_last  = c_last[w_sel];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_grant      <= '0;
            r_last       <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_idx   <= '0;
            r_last_grant <= GW'(INPUTS - 1);
        end else if (w_load) begin
            if (w_xfer) begin
                r_valid      <= 1'b1;
                r_data       <= w_data;
                r_grant      <= w_sel;
                r_last       <= w_last;
                r_last_grant <= w_sel;
                if (LOCKING != 0) begin
                    r_lock     <= !w_last;
                    r_lock_idx <= w_sel;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign p_valid = r_valid;
    assign p_data  = r_data;
    assign p_grant = r_grant;
    assign p_last  = r_last;

    a_ready_onehot: assert property (
        @(posedge clock) $onehot0(c_ready)
    );

    a_stall_no_ready: assert property (
        @(posedge clock) (p_valid && !p_ready) |-> (c_ready == '0)
    );

endmodule

// File: tb/tb_dc_rr_arbiter.sv
// Bench for dc_rr_arbiter: directed table, fairness sequence and
// randomized traffic against a cycle-level reference model.
module tb_dc_rr_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  cv;
    logic [63:0] cd;
    logic [3:0]  cl;
    logic        pr;

    logic [3:0]  rdy_l, rdy_n;
    logic        pv_l, pv_n;
    logic [15:0] pd_l, pd_n;
    logic [1:0]  pg_l, pg_n;
    logic        pl_l, pl_n;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] DCONST = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    always #5 clock = ~clock;

    dc_rr_arbiter #(.WIDTH(16), .INPUTS(4), .LOCKING(1)) u_l (
        .clock(clock), .reset(reset), .c_valid(cv), .c_data(cd),
        .c_last(cl), .c_ready(rdy_l), .p_valid(pv_l), .p_data(pd_l),
        .p_grant(pg_l), .p_last(pl_l), .p_ready(pr)
    );

    dc_rr_arbiter #(.WIDTH(16), .INPUTS(4), .LOCKING(0)) u_n (
        .clock(clock), .reset(reset), .c_valid(cv), .c_data(cd),
        .c_last(cl), .c_ready(rdy_n), .p_valid(pv_n), .p_data(pd_n),
        .p_grant(pg_n), .p_last(pl_n), .p_ready(pr)
    );

    // Reference model state: index 0 = locking DUT, 1 = non-locking DUT
    bit          m_ov[2];
    logic [15:0] m_od[2];
    int          m_og[2];
    bit          m_ol[2];
    bit          m_lock[2];
    int          m_lidx[2];
    int          m_lg[2];

    task automatic model_reset(input int m);
        m_ov[m] = 0; m_od[m] = '0; m_og[m] = 0; m_ol[m] = 0;
        m_lock[m] = 0; m_lidx[m] = 0; m_lg[m] = 3;
    endtask

    function automatic int pick(input int m, input logic [3:0] v);
        if (m_lock[m]) return m_lidx[m];
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_lg[m] + k) % 4]) return (m_lg[m] + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_inst(input int m, input logic [3:0] rdy,
                              input logic pv, input logic [15:0] pd,
                              input logic [1:0] pg, input logic pl);
        logic [3:0] er;
        bit load;
        int s;
        er = '0;
        if (reset) begin
            load = !m_ov[m] || pr;
            s = pick(m, cv);
            if (s >= 0 && load && (m_lock[m] || cv[s])) er[s] = 1'b1;
        end
        vectors++;
        if (rdy !== er || pv !== m_ov[m] || pd !== m_od[m]
            || pg !== 2'(m_og[m]) || pl !== m_ol[m]) begin
            miscompares++;
            $display("FAIL model%0d t=%0t got rdy=%b v=%b d=%h g=%0d l=%b want rdy=%b v=%b d=%h g=%0d l=%b",
                     m, $time, rdy, pv, pd, pg, pl,
                     er, m_ov[m], m_od[m], m_og[m], m_ol[m]);
        end
    endtask

    task automatic step_model(input int m);
        bit load;
        int s;
        if (!reset) begin
            model_reset(m);
        end else begin
            load = !m_ov[m] || pr;
            s = pick(m, cv);
            if (load) begin
                if (s >= 0 && cv[s]) begin
                    m_ov[m] = 1; m_od[m] = cd[s*16 +: 16];
                    m_og[m] = s; m_ol[m] = cl[s]; m_lg[m] = s;
                    if (m == 0) begin
                        m_lock[m] = !cl[s]; m_lidx[m] = s;
                    end
                end else begin
                    m_ov[m] = 0;
                end
            end
        end
    endtask

    task automatic drive_check(input logic r, input logic [3:0] v,
                               input logic [3:0] l, input logic p,
                               input logic [63:0] d);
        reset = r; cv = v; cl = l; pr = p; cd = d;
        @(negedge clock);
        check_inst(0, rdy_l, pv_l, pd_l, pg_l, pl_l);
        check_inst(1, rdy_n, pv_n, pd_n, pg_n, pl_n);
    endtask

    task automatic advance();
        step_model(0);
        step_model(1);
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic       pr;
        logic [3:0] e_rdy;
        logic       e_pv;
        logic [1:0] e_g;
    } vec_t;

    vec_t tbl[29];

    initial begin
        // reset hold, release, packet lock, stall, wrap, reset mid-packet
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[7]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[10] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[13] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[14] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[15] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[16] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[18] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd2};
        tbl[19] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3};
        tbl[20] = '{1'b1, 4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[21] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[22] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[23] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[24] = '{1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[25] = '{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[26] = '{1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[27] = '{1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[28] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};

        model_reset(0);
        model_reset(1);
        reset = 1'b0; cv = 4'hF; cl = '0; pr = 1'b1; cd = DCONST;
        @(posedge clock);
        #1;

        for (int i = 0; i < 29; i++) begin
            drive_check(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].pr, DCONST);
            vectors++;
            if (rdy_l !== tbl[i].e_rdy || pv_l !== tbl[i].e_pv
                || pg_l !== tbl[i].e_g
                || (tbl[i].e_pv && pd_l !== (16'hA000 + 16'(tbl[i].e_g)))) begin
                miscompares++;
                $display("FAIL table[%0d] got rdy=%b v=%b g=%0d d=%h want rdy=%b v=%b g=%0d",
                         i, rdy_l, pv_l, pg_l, pd_l,
                         tbl[i].e_rdy, tbl[i].e_pv, tbl[i].e_g);
            end
            advance();
        end

        // Fairness on the non-locking instance: A000,A001,A002,A003,A000
        drive_check(1'b0, 4'hF, 4'h0, 1'b1, DCONST);
        advance();
        for (int j = 0; j < 6; j++) begin
            drive_check(1'b1, 4'hF, 4'h0, 1'b1, DCONST);
            vectors++;
            if (j == 0) begin
                if (pv_n !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_first got v=%b want v=0", pv_n);
                end
            end else if (pv_n !== 1'b1
                         || pd_n !== (16'hA000 + 16'((j - 1) % 4))) begin
                miscompares++;
                $display("FAIL rr_seq[%0d] got v=%b d=%h want v=1 d=%h",
                         j, pv_n, pd_n, 16'hA000 + 16'((j - 1) % 4));
            end
            advance();
        end

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rl;
            for (int b = 0; b < 4; b++) rl[b] = ($urandom_range(0, 9) < 3);
            drive_check($urandom_range(0, 99) != 0, 4'($urandom), rl,
                        $urandom_range(0, 9) < 7, {$urandom, $urandom});
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
